fetch_unit: RTL and testbench

- Parametrised next-instruction / program-counter unit; successor to the fixed 8-bit PC block.
- Adds:
  - configurable PC and offset widths
  - conditional branch on Zero
  - absolute jump
  - call/return via a hardware return-address stack (RAS)
  - stall and halt
- Sits at the front of the core: drives PC to instruction memory; control decoder drives the request inputs.

---
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Program-counter / next-instruction unit with branch, jump,
// call/return stack, stall and halt.
module fetch_unit #(
  parameter int PC_W      = 8,
  parameter int OFF_W     = 6,
  parameter int RAS_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  Start_Addr,
  input  logic             Stall,
  input  logic             Branch,
  input  logic             BranchZ,
  input  logic             Zero,
  input  logic [OFF_W-1:0] Offset,
  input  logic             Jump,
  input  logic             Call,
  input  logic             Ret,
  input  logic [PC_W-1:0]  Target,
  input  logic             Halt,
  output logic [PC_W-1:0]  PC,
  output logic             Halted,
  output logic             RAS_Empty,
  output logic             RAS_Full,
  output logic             RAS_Err
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            err_q;
  logic            err_d;

  logic [PC_W-1:0] ras [RAS_DEPTH];
  logic            push;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   top_idx;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_rel;
  logic [PC_W-1:0] offs;
  logic            empty;
  logic            full;

  assign offs    = PC_W'($signed(Offset));
  assign pc_inc  = pc_q + PC_W'(1);
  assign pc_rel  = pc_q + offs;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(RAS_DEPTH));
  assign wr_idx  = AW'(cnt_q);
  assign top_idx = AW'(cnt_q - CW'(1));

  // Next-state selection in request priority order
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    push    = 1'b0;
    if (Start) begin
      state_d = RUN;
      pc_d    = Start_Addr;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (state_q == HALTED || Stall) begin
      state_d = state_q;
    end else begin
      if (Ret) begin
        if (!empty) begin
          pc_d  = ras[top_idx];
          cnt_d = cnt_q - CW'(1);
        end else begin
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
      end else if (Call) begin
        pc_d = Target;
        if (!full) begin
          push  = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (Jump) begin
        pc_d = Target;
      end else if (Branch || (BranchZ && Zero)) begin
        pc_d = pc_rel;
      end else begin
        pc_d = pc_inc;
      end
      if (Halt) begin
        state_d = HALTED;
      end
    end
  end

  // Control state registers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= RUN;
      pc_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Return-address storage; contents survive reset
  always_ff @(posedge CLK) begin
    if (push && !Reset) begin
      ras[wr_idx] <= pc_inc;
    end
  end

  assign PC        = pc_q;
  assign Halted    = (state_q == HALTED);
  assign RAS_Empty = empty;
  assign RAS_Full  = full;
  assign RAS_Err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based model
// compared every cycle plus hand-computed directed checks.
module tb_fetch_unit;

  localparam int PC_W  = 8;
  localparam int OFF_W = 6;
  localparam int DEPTH = 4;

  logic             CLK = 1'b0;
  logic             Reset;
  logic             Start;
  logic [PC_W-1:0]  Start_Addr;
  logic             Stall;
  logic             Branch;
  logic             BranchZ;
  logic             Zero;
  logic [OFF_W-1:0] Offset;
  logic             Jump;
  logic             Call;
  logic             Ret;
  logic [PC_W-1:0]  Target;
  logic             Halt;
  logic [PC_W-1:0]  PC;
  logic             Halted;
  logic             RAS_Empty;
  logic             RAS_Full;
  logic             RAS_Err;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  fetch_unit #(
    .PC_W(PC_W), .OFF_W(OFF_W), .RAS_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start),
    .Start_Addr(Start_Addr), .Stall(Stall),
    .Branch(Branch), .BranchZ(BranchZ), .Zero(Zero),
    .Offset(Offset), .Jump(Jump), .Call(Call),
    .Ret(Ret), .Target(Target), .Halt(Halt),
    .PC(PC), .Halted(Halted), .RAS_Empty(RAS_Empty),
    .RAS_Full(RAS_Full), .RAS_Err(RAS_Err)
  );

  always #5 CLK = ~CLK;

  // Reference model: stack is a queue, PC plain modular arithmetic
  logic [PC_W-1:0] m_pc = '0;
  bit              m_halt = 0;
  bit              m_err = 0;
  logic [PC_W-1:0] m_stk [$];

  always @(posedge CLK) begin
    if (Reset) begin
      m_pc = 0; m_halt = 0; m_err = 0; m_stk.delete();
    end else if (Start) begin
      m_pc = Start_Addr; m_halt = 0; m_err = 0; m_stk.delete();
    end else if (!m_halt && !Stall) begin
      if (Ret) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin m_pc = PC_W'(m_pc + 1); m_err = 1; end
      end else if (Call) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(PC_W'(m_pc + 1));
        else m_err = 1;
        m_pc = Target;
      end else if (Jump) begin
        m_pc = Target;
      end else if (Branch || (BranchZ && Zero)) begin
        m_pc = PC_W'(int'(m_pc) + int'($signed(Offset)));
      end else begin
        m_pc = PC_W'(m_pc + 1);
      end
      if (Halt) m_halt = 1;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, got, exp, $time);
    end
  endtask

  // Compare DUT against model on every falling edge once reset is seen
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("m_pc", PC, m_pc);
      chk("m_halted", Halted, m_halt);
      chk("m_empty", RAS_Empty, m_stk.size() == 0);
      chk("m_full", RAS_Full, m_stk.size() == DEPTH);
      chk("m_err", RAS_Err, m_err);
    end
  end

  task automatic idle();
    Reset = 0; Start = 0; Start_Addr = 0; Stall = 0;
    Branch = 0; BranchZ = 0; Zero = 0; Offset = 0;
    Jump = 0; Call = 0; Ret = 0; Target = 0; Halt = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_at(input logic [PC_W-1:0] a);
    idle(); Start = 1; Start_Addr = a; tick(); idle();
  endtask

  task automatic do_call(input logic [PC_W-1:0] t);
    idle(); Call = 1; Target = t; tick(); idle();
  endtask

  task automatic do_ret();
    idle(); Ret = 1; tick(); idle();
  endtask

  initial begin
    idle();
    Reset = 1;
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_pc", PC, 8'h00);
    chk("rst_empty", RAS_Empty, 1);
    chk("rst_full", RAS_Full, 0);
    chk("rst_err", RAS_Err, 0);
    chk("rst_halted", Halted, 0);
    idle();
    tick(); tick(); tick();
    chk("run_pc3", PC, 8'h03);

    start_at(8'h10);
    chk("start_10", PC, 8'h10);
    tick();
    chk("inc_11", PC, 8'h11);
    Branch = 1; Offset = 6'h3E; tick(); idle();
    chk("br_m2", PC, 8'h0F);
    BranchZ = 1; Offset = 6'h04; Zero = 0; tick();
    chk("bz_nt", PC, 8'h10);
    Zero = 1; tick(); idle();
    chk("bz_t", PC, 8'h14);

    start_at(8'hFE);
    tick();
    chk("wrap_ff", PC, 8'hFF);
    tick();
    chk("wrap_00", PC, 8'h00);
    start_at(8'h02);
    Branch = 1; Offset = 6'h3D; tick(); idle();
    chk("br_wrap", PC, 8'hFF);

    start_at(8'h20);
    do_call(8'h30);
    do_call(8'h40);
    do_call(8'h50);
    do_call(8'h60);
    chk("call4_pc", PC, 8'h60);
    chk("call4_full", RAS_Full, 1);
    chk("call4_err", RAS_Err, 0);
    do_call(8'h70);
    chk("call5_pc", PC, 8'h70);
    chk("call5_err", RAS_Err, 1);
    chk("call5_full", RAS_Full, 1);
    do_ret();
    chk("ret1", PC, 8'h51);
    chk("ret1_full", RAS_Full, 0);
    do_ret();
    chk("ret2", PC, 8'h41);
    do_ret();
    chk("ret3", PC, 8'h31);
    do_ret();
    chk("ret4", PC, 8'h21);
    chk("ret4_empty", RAS_Empty, 1);
    do_ret();
    chk("ret5", PC, 8'h22);
    chk("ret5_err", RAS_Err, 1);

    start_at(8'h80);
    chk("start_clr_err", RAS_Err, 0);
    do_call(8'h90);
    Stall = 1; Branch = 1; Offset = 6'h05;
    Call = 1; Target = 8'hC0; Halt = 1;
    tick(); tick(); idle();
    chk("stall_pc", PC, 8'h90);
    chk("stall_empty", RAS_Empty, 0);
    chk("stall_halt", Halted, 0);
    Call = 1; Ret = 1; Target = 8'hA0; tick(); idle();
    chk("callret_pc", PC, 8'h81);
    chk("callret_empty", RAS_Empty, 1);

    start_at(8'h04);
    do_ret();
    chk("pre_halt_err", RAS_Err, 1);
    Halt = 1; tick(); idle();
    chk("halt_pc", PC, 8'h06);
    chk("halt_flag", Halted, 1);
    Jump = 1; Target = 8'h33;
    for (int i = 0; i < 10; i++) tick();
    idle();
    chk("halt_hold", PC, 8'h06);
    start_at(8'h40);
    chk("restart_pc", PC, 8'h40);
    chk("restart_halt", Halted, 0);
    chk("restart_err", RAS_Err, 0);
    do_call(8'h50);
    do_call(8'h60);
    Halt = 1; tick(); idle();
    chk("halt2_pc", PC, 8'h61);
    chk("halt2_flag", Halted, 1);
    Reset = 1; tick(); idle();
    chk("rst2_pc", PC, 8'h00);
    chk("rst2_halt", Halted, 0);
    chk("rst2_empty", RAS_Empty, 1);
    chk("rst2_err", RAS_Err, 0);
    tick();
    chk("rst2_run", PC, 8'h01);

    @(negedge CLK);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
